// File: rtl/sqrt_req_arbiter.sv
// Round-robin front end sharing one 16-bit square-root engine among NUM_REQ clients.
// Each job runs under a watchdog, and the returned root is range-checked before it goes back.
module sqrt_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 512,
  parameter int TO_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [16*NUM_REQ-1:0]   req_valor_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [7:0]              rsp_root_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [1:0]              rsp_err_o,
  output logic                    eng_start_o,
  output logic [15:0]             eng_valor_o,
  output logic                    eng_rst_n_o,
  input  logic                    eng_ready_i,
  input  logic [7:0]              eng_root_i,
  output logic                    busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ABORT, S_RESP} state_t;

  localparam logic [ID_W-1:0] LAST_IDX   = ID_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic [ID_W-1:0] id_q;
  logic [15:0]     operand_q;
  logic [7:0]      root_q;
  logic [1:0]      err_q;
  logic [TO_W-1:0] timer;
  logic            eng_done;
  logic            check_ok;
  logic [8:0]      root_p1;
  logic [16:0]     root_sq;
  logic [16:0]     root_p1_sq;

  // Search for the first pending request starting at rr_ptr and wrapping around.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid_i[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // A ready seen at timer==0 may be left over from the previous job, so it is ignored.
  assign eng_done = (state == S_WAIT) && eng_ready_i && (timer != '0);

  always_comb begin
    root_p1    = {1'b0, eng_root_i} + 9'd1;
    root_sq    = {9'b0, eng_root_i} * {9'b0, eng_root_i};
    root_p1_sq = {8'b0, root_p1} * {8'b0, root_p1};
    check_ok   = (root_sq <= {1'b0, operand_q}) && ({1'b0, operand_q} < root_p1_sq);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready_o = '0;
    eng_start_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found && rst_n) begin
          req_ready_o = NUM_REQ'(1) << grant_idx;
          state_next  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        eng_start_o = 1'b1;
        state_next  = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done)                 state_next = S_RESP;
        else if (timer == TIMER_LAST) state_next = S_ABORT;
      end
      S_ABORT: state_next = S_RESP;
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_o      = (state != S_IDLE);
  assign eng_rst_n_o = rst_n && (state != S_ABORT);
  assign eng_valor_o = operand_q;
  assign rsp_root_o  = root_q;
  assign rsp_id_o    = id_q;
  assign rsp_err_o   = err_q;

  // Job context: operand and id latched on grant, result and status latched on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      operand_q <= '0;
      root_q    <= '0;
      err_q     <= '0;
      timer     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            operand_q <= req_valor_i[{grant_idx, 4'b0000} +: 16];
            id_q      <= grant_idx;
            rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          end
        end
        S_LAUNCH: timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (eng_done) begin
            root_q <= eng_root_i;
            err_q  <= check_ok ? 2'b00 : 2'b10;
          end
        end
        S_ABORT: begin
          root_q <= '0;
          err_q  <= 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// Self-checking bench for sqrt_req_arbiter: a constant vector table, two hand sequences
// (stalled response, reset mid-job) and randomized jobs checked against a transaction model.
module tb_sqrt_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 20;
  localparam int TO_W    = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [16*NUM_REQ-1:0] req_valor_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [7:0]            rsp_root_o;
  logic [ID_W-1:0]       rsp_id_o;
  logic [1:0]            rsp_err_o;
  logic                  eng_start_o;
  logic [15:0]           eng_valor_o;
  logic                  eng_rst_n_o;
  logic                  eng_ready_i;
  logic [7:0]            eng_root_i;
  logic                  busy_o;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] ops;
    int          lat;
    logic [7:0]  eroot;
    bit          hold;
    int          stall;
    int          exp_id;
    logic [7:0]  exp_root;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t tbl[14];

  sqrt_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_valor_i(req_valor_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_root_o(rsp_root_o),
    .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
    .eng_start_o(eng_start_o), .eng_valor_o(eng_valor_o), .eng_rst_n_o(eng_rst_n_o),
    .eng_ready_i(eng_ready_i), .eng_root_i(eng_root_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] mask, input logic [63:0] ops, input int lat,
                              input logic [7:0] eroot, input bit hold, input int stall,
                              input int exp_id, input logic [7:0] exp_root,
                              input logic [1:0] exp_err);
    vec_t v;
    v.mask = mask; v.ops = ops; v.lat = lat; v.eroot = eroot; v.hold = hold;
    v.stall = stall; v.exp_id = exp_id; v.exp_root = exp_root; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete job: grant, launch, engine behaviour, response and hand-back to idle.
  task automatic applyStimulus(input vec_t v);
    logic [63:0] ops_l;
    logic [15:0] exp_op;
    int          exp_lat;
    int          idx;
    int          c;
    int          rst_low;
    int          extra_start;
    int          bad_ready;
    bit          seen;
    bit          real_ready;
    ops_l   = v.ops;
    exp_op  = ops_l[16*v.exp_id +: 16];
    exp_lat = (v.lat >= 1 && v.lat <= TIMEOUT - 1) ? v.lat + 3 : TIMEOUT + 3;
    req_valid_i = v.mask;
    req_valor_i = v.ops;
    rsp_ready_i = (v.stall == 0);
    eng_ready_i = v.hold;
    eng_root_i  = 8'hAA;
    #1;
    checkOutput("grant", req_ready_o, 64'(1) << v.exp_id);
    checkOutput("idle_busy", busy_o, 0);
    @(negedge clk);
    checkOutput("launch_start", eng_start_o, 1);
    checkOutput("launch_valor", eng_valor_o, exp_op);
    checkOutput("launch_no_grant", req_ready_o, 0);
    idx = 1; seen = 0; rst_low = 0; extra_start = 0; bad_ready = 0;
    while (!seen && idx < TIMEOUT + 10) begin
      @(negedge clk);
      idx++;
      if (rsp_valid_o) seen = 1;
      else begin
        c = idx - 2;
        if (!eng_rst_n_o) rst_low++;
        if (eng_start_o) extra_start++;
        if (req_ready_o != 0) bad_ready++;
        real_ready  = (v.lat >= 1) && (c >= v.lat);
        eng_ready_i = real_ready || (v.hold && c == 0);
        eng_root_i  = real_ready ? v.eroot : 8'hAA;
      end
    end
    checkOutput("rsp_seen", seen, 1);
    checkOutput("latency", idx, exp_lat);
    checkOutput("rsp_root", rsp_root_o, v.exp_root);
    checkOutput("rsp_id", rsp_id_o, v.exp_id);
    checkOutput("rsp_err", rsp_err_o, v.exp_err);
    checkOutput("eng_rst_pulses", rst_low, (v.exp_err == 2'b01) ? 1 : 0);
    checkOutput("extra_start", extra_start, 0);
    checkOutput("busy_grant", bad_ready, 0);
    eng_ready_i = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      checkOutput("stall_valid", rsp_valid_o, 1);
      checkOutput("stall_root", rsp_root_o, v.exp_root);
      checkOutput("stall_id", rsp_id_o, v.exp_id);
      checkOutput("stall_no_grant", req_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checkOutput("back_idle", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   rr;
    int   rsp_cnt;
    int   op;
    int   r;
    int   pick;
    bit   tmo;
    tests_run = 0; tests_failed = 0;

    tbl[0]  = mk(4'b0001, 64'h0000_0000_0000_0019,  5, 8'd5,  0, 0, 0, 8'd5,  2'b00);
    tbl[1]  = mk(4'b1111, 64'h0000_0002_0051_0064,  1, 8'd9,  0, 0, 1, 8'd9,  2'b00);
    tbl[2]  = mk(4'b1111, 64'h0000_0002_0051_0064,  2, 8'd1,  0, 0, 2, 8'd1,  2'b00);
    tbl[3]  = mk(4'b1111, 64'h0000_0002_0051_0064,  3, 8'd0,  0, 0, 3, 8'd0,  2'b00);
    tbl[4]  = mk(4'b1111, 64'h0000_0002_0051_0064,  4, 8'd10, 0, 0, 0, 8'd10, 2'b00);
    tbl[5]  = mk(4'b1111, 64'hAAAA_BBBB_00FF_CCCC,  2, 8'h10, 0, 0, 1, 8'h10, 2'b10);
    tbl[6]  = mk(4'b0100, 64'h1111_FFFF_2222_3333,  1, 8'hFF, 0, 0, 2, 8'hFF, 2'b00);
    tbl[7]  = mk(4'b0010, 64'h5555_6666_0010_7777,  7, 8'd4,  0, 0, 1, 8'd4,  2'b00);
    tbl[8]  = mk(4'b1000, 64'h1234_0000_0000_0000, -1, 8'd0,  0, 0, 3, 8'd0,  2'b01);
    tbl[9]  = mk(4'b0001, 64'h0000_0000_0000_0090, 19, 8'd12, 0, 0, 0, 8'd12, 2'b00);
    tbl[10] = mk(4'b0001, 64'h0000_0000_0000_0001,  2, 8'd1,  1, 0, 0, 8'd1,  2'b00);
    tbl[11] = mk(4'b0100, 64'h0000_0010_0000_0000,  1, 8'd3,  0, 0, 2, 8'd3,  2'b10);
    tbl[12] = mk(4'b1111, 64'h0031_0001_0002_0003,  2, 8'd7,  0, 10, 3, 8'd7, 2'b00);
    tbl[13] = mk(4'b1111, 64'h0000_0000_0000_0004,  1, 8'd2,  0, 0, 0, 8'd2,  2'b00);

    rst_n = 1'b0; req_valid_i = 4'hF; req_valor_i = '0; rsp_ready_i = 1'b0;
    eng_ready_i = 1'b0; eng_root_i = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_eng_start", eng_start_o, 0);
    checkOutput("rst_eng_rst_n", eng_rst_n_o, 0);
    checkOutput("rst_root", rsp_root_o, 0);
    checkOutput("rst_err", rsp_err_o, 0);
    rst_n = 1'b1; req_valid_i = '0;
    @(negedge clk);
    checkOutput("run_eng_rst_n", eng_rst_n_o, 1);

    for (int i = 0; i < 13; i++) applyStimulus(tbl[i]);

    // Reset while the engine is running: job dropped, pointer back to 0.
    req_valid_i = 4'b0010; req_valor_i = 64'h0000_0000_0100_0000;
    eng_ready_i = 1'b0; rsp_ready_i = 1'b1;
    #1;
    checkOutput("rw_grant", req_ready_o, 4'b0010);
    repeat (4) @(negedge clk);
    checkOutput("rw_busy", busy_o, 1);
    rst_n = 1'b0; req_valid_i = '0;
    #1;
    checkOutput("rw_eng_rst", eng_rst_n_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rw_idle", busy_o, 0);
    eng_ready_i = 1'b1; eng_root_i = 8'h10;
    rsp_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid_o || eng_start_o) rsp_cnt++;
    end
    checkOutput("rw_no_rsp", rsp_cnt, 0);
    applyStimulus(tbl[13]);

    rr = 1;
    for (int n = 0; n < 40; n++) begin
      v.mask  = 4'($urandom_range(1, 15));
      v.ops   = {$urandom(), $urandom()};
      v.exp_id = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (v.exp_id < 0 && v.mask[(rr + k) % NUM_REQ]) v.exp_id = (rr + k) % NUM_REQ;
      op = int'(v.ops[16*v.exp_id +: 16]);
      r  = isqrt(op);
      v.eroot = ($urandom_range(0, 3) != 0) ? 8'(r) : 8'($urandom_range(0, 255));
      pick = $urandom_range(0, 9);
      v.lat = (pick < 7) ? $urandom_range(1, 6) : (pick == 7) ? TIMEOUT - 1 :
              (pick == 8) ? -1 : TIMEOUT;
      v.hold  = $urandom_range(0, 1);
      v.stall = $urandom_range(0, 2);
      tmo = !(v.lat >= 1 && v.lat <= TIMEOUT - 1);
      v.exp_root = tmo ? 8'd0 : v.eroot;
      if (tmo) v.exp_err = 2'b01;
      else if (int'(v.eroot) * int'(v.eroot) <= op && op < (int'(v.eroot) + 1) * (int'(v.eroot) + 1))
        v.exp_err = 2'b00;
      else v.exp_err = 2'b10;
      applyStimulus(v);
      rr = (v.exp_id + 1) % NUM_REQ;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
